// File: rtl/call_stack.sv
// ============================================================================
//  Module   : call_stack
//  Brief    : Return-address stack for the Harvard CPU core (CALL/RET).
//             Define CALL_STACK_WRAP_EN to let full pushes overwrite the oldest entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module call_stack #(
  parameter int DEPTH_LOG2 = 3,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_W-1:0]     push_data,
  output logic [ADDR_W-1:0]     top_data,
  output logic [DEPTH_LOG2:0]   sp,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                c_depth     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_depth_cnt = (DEPTH_LOG2 + 1)'(c_depth);

  logic [ADDR_W-1:0]     r_mem [c_depth];
  logic [DEPTH_LOG2:0]   r_sp;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [DEPTH_LOG2-1:0] w_bot;
  logic [DEPTH_LOG2-1:0] w_top_idx;
  logic [DEPTH_LOG2-1:0] w_push_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [DEPTH_LOG2:0]   w_sp_nxt;
  logic                  w_wr_en;
  logic                  w_set_ovf;
  logic                  w_set_unf;
  logic                  w_empty;
  logic                  w_full;

  // At sp == DEPTH the low sp bits are zero, so push_idx lands on bot (oldest entry).
  assign w_top_idx  = w_bot + r_sp[DEPTH_LOG2-1:0] - 1'b1;
  assign w_push_idx = w_bot + r_sp[DEPTH_LOG2-1:0];
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == c_depth_cnt);

  assign sp        = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign top_data  = w_empty ? '0 : r_mem[w_top_idx];

`ifdef CALL_STACK_WRAP_EN
  logic [DEPTH_LOG2-1:0] r_bot;
  logic                  w_bot_inc;

  assign w_bot     = r_bot;
  assign w_bot_inc = push && !pop && w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bot <= '0;
    end else if (w_bot_inc) begin
      r_bot <= r_bot + 1'b1;
    end
  end
`else
  assign w_bot = '0;
`endif

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = w_push_idx;
    w_sp_nxt  = r_sp;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!w_full) begin
          w_wr_en  = 1'b1;
          w_sp_nxt = r_sp + 1'b1;
        end else begin
          w_set_ovf = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          w_wr_en   = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!w_empty) begin
          w_sp_nxt = r_sp - 1'b1;
        end else begin
          w_set_unf = 1'b1;
        end
      end
      2'b11: begin
        // RET immediately followed by CALL: overwrite the top in place.
        w_wr_en = 1'b1;
        if (!w_empty) begin
          w_wr_idx = w_top_idx;
        end else begin
          w_sp_nxt  = r_sp + 1'b1;
          w_set_unf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_sp <= w_sp_nxt;
      if (w_set_ovf) r_overflow <= 1'b1;
      if (w_set_unf) r_underflow <= 1'b1;
      if (w_wr_en) r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_call_stack.sv
// ============================================================================
//  Module   : tb_call_stack
//  Brief    : Directed self-checking bench for call_stack.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_call_stack;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic [7:0] push_data;
  logic [7:0] top_data;
  logic [3:0] sp;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int vecs;
  int errs;

  call_stack #(.DEPTH_LOG2(3), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top_data  (top_data),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one strobe pattern across a single rising edge; returns #1 after it.
  task automatic step(input logic pu, input logic po, input logic [7:0] d);
    @(negedge clk);
    push      = pu;
    pop       = po;
    push_data = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (sp !== 4'd0)       begin errs++; $display("FAIL reset_sp got=%0d exp=0", sp); end
    vecs++; if (top_data !== 8'h0) begin errs++; $display("FAIL reset_top got=%h exp=00", top_data); end
    vecs++; if ({empty, full, overflow, underflow} !== 4'b1000)
      begin errs++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, overflow, underflow}); end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_top [3];
    exp_top = '{8'h20, 8'h10, 8'h00};
    do_reset();
    step(1, 0, 8'h10);
    step(1, 0, 8'h20);
    step(1, 0, 8'h30);
    vecs++; if (sp !== 4'd3)        begin errs++; $display("FAIL pp_sp got=%0d exp=3", sp); end
    vecs++; if (top_data !== 8'h30) begin errs++; $display("FAIL pp_top got=%h exp=30", top_data); end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h00);
      vecs++; if (top_data !== exp_top[i])
        begin errs++; $display("FAIL pp_pop%0d got=%h exp=%h", i, top_data, exp_top[i]); end
    end
    vecs++; if ({empty, overflow, underflow} !== 3'b100)
      begin errs++; $display("FAIL pp_flags got=%b exp=100", {empty, overflow, underflow}); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(0, 1, 8'h00);
    vecs++; if (sp !== 4'd0 || underflow !== 1'b1)
      begin errs++; $display("FAIL unf_set sp=%0d unf=%b exp sp=0 unf=1", sp, underflow); end
    step(1, 0, 8'h11);
    step(0, 1, 8'h00);
    vecs++; if (underflow !== 1'b1 || empty !== 1'b1)
      begin errs++; $display("FAIL unf_sticky unf=%b empty=%b exp 1 1", underflow, empty); end
    do_reset();
    vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL unf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(i));
    vecs++; if (full !== 1'b1 || top_data !== 8'h08 || overflow !== 1'b0)
      begin errs++; $display("FAIL fill full=%b top=%h ovf=%b exp 1 08 0", full, top_data, overflow); end
    step(1, 0, 8'h09);
`ifdef CALL_STACK_WRAP_EN
    exp = 8'h09;
`else
    exp = 8'h08;
`endif
    vecs++; if (sp !== 4'd8 || overflow !== 1'b1 || top_data !== exp)
      begin errs++; $display("FAIL ovf_push sp=%0d ovf=%b top=%h exp 8 1 %h", sp, overflow, top_data, exp); end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (top_data !== exp)
        begin errs++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, top_data, exp); end
      step(0, 1, 8'h00);
      exp = exp - 8'h01;
    end
    vecs++; if (empty !== 1'b1 || top_data !== 8'h00 || underflow !== 1'b0)
      begin errs++; $display("FAIL ovf_end empty=%b top=%h unf=%b exp 1 00 0", empty, top_data, underflow); end
  endtask

  task automatic test_replace();
    do_reset();
    step(1, 0, 8'h40);
    step(1, 0, 8'h50);
    step(1, 1, 8'h60);
    vecs++; if (sp !== 4'd2 || top_data !== 8'h60)
      begin errs++; $display("FAIL repl sp=%0d top=%h exp 2 60", sp, top_data); end
    step(0, 1, 8'h00);
    vecs++; if (sp !== 4'd1 || top_data !== 8'h40)
      begin errs++; $display("FAIL repl_pop sp=%0d top=%h exp 1 40", sp, top_data); end
  endtask

  task automatic test_full_replace();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(i));
    step(1, 1, 8'hAA);
    vecs++; if (sp !== 4'd8 || top_data !== 8'hAA || overflow !== 1'b0)
      begin errs++; $display("FAIL full_repl sp=%0d top=%h ovf=%b exp 8 aa 0", sp, top_data, overflow); end
    step(0, 1, 8'h00);
    vecs++; if (top_data !== 8'h07) begin errs++; $display("FAIL full_repl_pop got=%h exp=07", top_data); end
  endtask

  task automatic test_push_pop_empty();
    do_reset();
    step(1, 1, 8'h77);
    vecs++; if (sp !== 4'd1 || top_data !== 8'h77 || underflow !== 1'b1 || overflow !== 1'b0)
      begin errs++; $display("FAIL pp_empty sp=%0d top=%h unf=%b ovf=%b exp 1 77 1 0",
                             sp, top_data, underflow, overflow); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 0, 8'(8'h80 + i));
    @(negedge clk);
    push      = 1'b1;
    push_data = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if (sp !== 4'd0 || top_data !== 8'h00 || empty !== 1'b1)
      begin errs++; $display("FAIL arst sp=%0d top=%h empty=%b exp 0 00 1", sp, top_data, empty); end
    @(posedge clk);
    #1;
    push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vecs++; if (sp !== 4'd0 || empty !== 1'b1)
      begin errs++; $display("FAIL arst_release sp=%0d empty=%b exp 0 1", sp, empty); end
    step(1, 0, 8'h5A);
    vecs++; if (sp !== 4'd1 || top_data !== 8'h5A)
      begin errs++; $display("FAIL arst_push sp=%0d top=%h exp 1 5a", sp, top_data); end
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    rst_n     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = 8'h00;
    test_reset();
    test_push_pop();
    test_underflow();
    test_fill_overflow();
    test_replace();
    test_full_replace();
    test_push_pop_empty();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/call_stack.md
Name: call_stack

Overview:
- Return-address stack storage for the Harvard CPU core.
- Consumes the core's push (CALL) and pop (RET) strobes.
- Holds up to 2**DEPTH_LOG2 program-counter values and owns its own pointer register.
- Drives the top-of-stack address to the PC mux for RET, plus full/empty status and sticky error flags to the control unit.

Parameters:
- DEPTH_LOG2, 3, log2 of entry count (default 8 entries).
- ADDR_W, 8, width of one stored program address.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  CALL strobe; store push_data as new top on this edge.
- pop  in  1  RET strobe; discard current top on this edge.
- push_data  in  ADDR_W  return address to store (PC+1 supplied by core).
- top_data  out  ADDR_W  current top entry; 0 when empty.
- sp  out  DEPTH_LOG2+1  current entry count, 0..DEPTH.
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- overflow  out  1  sticky; push rejected (or wrapped) while full.
- underflow  out  1  sticky; pop requested while empty.

Behaviour:
- DEPTH = 2**DEPTH_LOG2.
- Storage: DEPTH x ADDR_W register array.
  - bot: DEPTH_LOG2-bit base index.
  - sp: count register.
  - Physical top index = (bot + sp - 1) mod DEPTH.
- Reset: asynchronous, on rst_n low.
  - sp=0, bot=0, all entries 0, overflow=0, underflow=0.
  - Outputs at reset: top_data=0, empty=1, full=0.
  - Reset asserted mid-operation discards the pending strobe and all contents immediately.
- Outputs are combinational from registered state only; no input-to-output paths.
  - A push at edge N makes push_data visible on top_data right after edge N (zero-cycle read after the edge).
  - A pop at edge N makes the previous entry visible on top_data after edge N.
  - Core samples top_data in the same cycle it asserts pop.
- Per-edge update, evaluated on {push, pop}:
  - 00: hold.
  - 10, not full: mem[(bot+sp) mod DEPTH] <= push_data; sp <= sp+1.
  - 10, full: see Optional Feature; default is write suppressed, sp held, overflow <= 1.
  - 01, not empty: sp <= sp-1; memory untouched.
  - 01, empty: sp held at 0; underflow <= 1.
  - 11, not empty: replace top in place, i.e. mem[top] <= push_data, sp unchanged (RET immediately followed by CALL). Never flags overflow, even when full.
  - 11, empty: behaves as push (sp <= 1, entry written); underflow <= 1.
- Sticky flags clear only on reset.
- sp arithmetic uses DEPTH_LOG2+1 bits and never wraps past 0 or DEPTH.
- Index arithmetic is modulo DEPTH.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN.
- Defined: push while full (without pop) writes push_data over the oldest entry at index bot, then bot <= bot+1.
  - sp stays DEPTH; overflow <= 1.
  - Stack acts as a circular buffer keeping the newest DEPTH return addresses; subsequent pops return newest-first.
- Undefined: bot is a constant 0 (register removed); full-push is dropped as above.
- Both builds share the port list.

Test Plan:
- Reset then 3 pushes 0x10,0x20,0x30 -> sp=3, top_data=0x30 after third edge; 3 pops -> top_data 0x20, 0x10, then 0 with empty=1; flags stay 0.
- Pop on empty -> sp=0, underflow=1 and remains 1 through later valid push/pop; rst_n low -> underflow=0.
- Fill 8 pushes 0x01..0x08 -> full=1, top=0x08.
  - 9th push 0x09, default build -> sp=8, top=0x08, overflow=1; 8 pops return 0x08..0x01.
  - WRAP_EN build -> top=0x09; 8 pops return 0x09..0x02.
- Push 0x40, push 0x50, then push+pop with push_data 0x60 -> sp=2, top=0x60; pop -> top=0x40.
- Push+pop with push_data 0x77 on empty -> sp=1, top=0x77, underflow=1, overflow=0.
- Assert rst_n low asynchronously mid-cycle with sp=5 and push high -> sp=0, top_data=0, empty=1 before next clk edge; no write after release until the next strobe.
